// File: rtl/twiddle_cordic.sv
// Sequential CORDIC twiddle generator: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N).
// The angle within the quadrant is rotated by micro-rotations, then the quadrant
// bits fold the result. Output is signed Q1.(WIDTH-1), symmetric saturation.
module twiddle_cordic #(
  parameter int WIDTH = 16,
  parameter int LOG_N = 6,
  parameter int ITER  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_en,
  input  logic [LOG_N-1:0] req_k,
  output logic             busy,
  output logic             do_en,
  output logic [WIDTH-1:0] tw_re,
  output logic [WIDTH-1:0] tw_im
);

  localparam int ZW = WIDTH + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic signed [ZW-1:0] MAXV = ZW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [ZW-1:0] MINV = -MAXV;

  // Gain-precompensated start vector: round(2^(WIDTH-1) / 1.646760258).
  function automatic logic signed [ZW-1:0] x_init();
    longint p;
    p = 64'sd1 <<< (WIDTH - 1);
    return ZW'((p * 64'sd607252935 + 64'sd500000000) / 64'sd1000000000);
  endfunction

  // atan(2^-i) with a full turn = 2^32, rounded down to a full turn = 2^ZW.
  function automatic logic [ZW-1:0] atan_z(input int i);
    longint unsigned v;
    case (i)
      0:  v = 64'd536870912;
      1:  v = 64'd316933406;
      2:  v = 64'd167458907;
      3:  v = 64'd85004756;
      4:  v = 64'd42667331;
      5:  v = 64'd21354465;
      6:  v = 64'd10679838;
      7:  v = 64'd5340245;
      8:  v = 64'd2670163;
      9:  v = 64'd1335087;
      10: v = 64'd667544;
      11: v = 64'd333772;
      12: v = 64'd166886;
      13: v = 64'd83443;
      14: v = 64'd41722;
      15: v = 64'd20861;
      16: v = 64'd10430;
      17: v = 64'd5215;
      18: v = 64'd2608;
      19: v = 64'd1304;
      default: v = 64'd683565276 >> i;
    endcase
    return ZW'((v + (64'd1 << (31 - ZW))) >> (32 - ZW));
  endfunction

  // Arithmetic shift right with round-half-up, keeping truncation bias out of the
  // accumulated rotation error.
  function automatic logic signed [ZW-1:0] rsh(input logic signed [ZW-1:0] v,
                                               input logic [CW-1:0] sh);
    logic signed [ZW-1:0] bias;
    bias = '0;
    if (sh != '0) bias[sh - 1'b1] = 1'b1;
    return (v + bias) >>> sh;
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [ZW-1:0] v);
    if (v > MAXV)      return WIDTH'(MAXV);
    else if (v < MINV) return WIDTH'(MINV);
    else               return v[WIDTH-1:0];
  endfunction

  typedef enum logic {IDLE, ROT} state_t;

  logic [ZW-1:0] atan_tab [ITER];

  for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
    assign atan_tab[gi] = atan_z(gi);
  end

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [ZW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [1:0]            quad_q, quad_d;
  logic                  byp_q, byp_d;
  logic                  do_en_q, do_en_d;
  logic [WIDTH-1:0]      re_q, re_d, im_q, im_d;

  logic signed [ZW-1:0]  x_rot, y_rot, z_rot, c_fin, s_fin, cos_w, sin_w;
  logic                  dir_pos;

  // One micro-rotation of the current vector plus the quadrant fold of its result.
  always_comb begin
    dir_pos = ~z_q[ZW-1];
    if (dir_pos) begin
      x_rot = x_q - rsh(y_q, cnt_q);
      y_rot = y_q + rsh(x_q, cnt_q);
      z_rot = z_q - $signed(atan_tab[cnt_q]);
    end else begin
      x_rot = x_q + rsh(y_q, cnt_q);
      y_rot = y_q - rsh(x_q, cnt_q);
      z_rot = z_q + $signed(atan_tab[cnt_q]);
    end
    c_fin = byp_q ? MAXV : x_rot;
    s_fin = byp_q ? '0   : y_rot;
    case (quad_q)
      2'd0:    begin cos_w =  c_fin; sin_w =  s_fin; end
      2'd1:    begin cos_w = -s_fin; sin_w =  c_fin; end
      2'd2:    begin cos_w = -c_fin; sin_w = -s_fin; end
      default: begin cos_w =  s_fin; sin_w = -c_fin; end
    endcase
  end

  // Next-state: accept in IDLE, iterate in ROT, publish the result on the last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    quad_d  = quad_q;
    byp_d   = byp_q;
    do_en_d = 1'b0;
    re_d    = re_q;
    im_d    = im_q;
    case (state_q)
      IDLE: begin
        if (req_en) begin
          state_d = ROT;
          cnt_d   = '0;
          x_d     = x_init();
          y_d     = '0;
          z_d     = {2'b00, req_k[LOG_N-3:0], {(ZW-LOG_N){1'b0}}};
          quad_d  = req_k[LOG_N-1 -: 2];
          byp_d   = (req_k[LOG_N-3:0] == '0);
        end
      end
      default: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          do_en_d = 1'b1;
          re_d    = sat(cos_w);
          im_d    = sat(-sin_w);
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any request in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      quad_q  <= '0;
      byp_q   <= 1'b0;
      do_en_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      quad_q  <= quad_d;
      byp_q   <= byp_d;
      do_en_q <= do_en_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign busy  = (state_q == ROT);
  assign do_en = do_en_q;
  assign tw_re = re_q;
  assign tw_im = im_q;

endmodule

// File: tb/tb_twiddle_cordic.sv
// Directed bench for twiddle_cordic (N=64, WIDTH=16, ITER=16).
module tb_twiddle_cordic;

  localparam int WIDTH = 16;
  localparam int LOG_N = 6;
  localparam int ITER  = 16;
  localparam real PI   = 3.14159265358979;

  logic             clock;
  logic             reset;
  logic             req_en;
  logic [LOG_N-1:0] req_k;
  logic             busy;
  logic             do_en;
  logic [WIDTH-1:0] tw_re;
  logic [WIDTH-1:0] tw_im;

  int checks   = 0;
  int failures = 0;

  twiddle_cordic #(.WIDTH(WIDTH), .LOG_N(LOG_N), .ITER(ITER)) dut (
    .clock (clock),
    .reset (reset),
    .req_en(req_en),
    .req_k (req_k),
    .busy  (busy),
    .do_en (do_en),
    .tw_re (tw_re),
    .tw_im (tw_im)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int k;
    int re;
    int im;
    int tol;
  } vec_t;

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int ideal_re(input int k);
    return rnd(32767.0 * $cos(2.0 * PI * k / 64.0));
  endfunction

  function automatic int ideal_im(input int k);
    return rnd(-32767.0 * $sin(2.0 * PI * k / 64.0));
  endfunction

  function automatic int sre();
    return int'($signed(tw_re));
  endfunction

  function automatic int sim_();
    return int'($signed(tw_im));
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    int diff;
    checks++;
    diff = (act > exp) ? act - exp : exp - act;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, exp, tol);
    end else begin
      $display("ok   %s actual=%0d required=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  // Issue one request and wait for its result; lat counts the request cycle as 0.
  task automatic run_req(input int k, output int lat, output int re, output int im);
    @(negedge clock);
    req_en = 1'b1;
    req_k  = k[LOG_N-1:0];
    @(posedge clock);
    #1;
    req_en = 1'b0;
    check($sformatf("busy_after_accept k=%0d", k), int'(busy), 1, 0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (do_en) begin
        lat = n + 1;
        break;
      end
    end
    re = sre();
    im = sim_();
  endtask

  vec_t vecs[8];

  initial begin
    int lat, re, im, pulses, extra, cur, ecnt, last, keep_re, keep_im;

    vecs[0] = '{k: 0,  re:  32767, im:      0, tol: 0};
    vecs[1] = '{k: 16, re:      0, im: -32767, tol: 0};
    vecs[2] = '{k: 32, re: -32767, im:      0, tol: 0};
    vecs[3] = '{k: 48, re:      0, im:  32767, tol: 0};
    vecs[4] = '{k: 8,  re:  23170, im: -23170, tol: 4};
    vecs[5] = '{k: 56, re:  23170, im:  23170, tol: 4};
    vecs[6] = '{k: 4,  re:  30273, im: -12539, tol: 4};
    vecs[7] = '{k: 40, re: -23170, im:  23170, tol: 4};

    reset  = 1'b1;
    req_en = 1'b0;
    req_k  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy",  int'(busy),  0, 0);
    check("reset_do_en", int'(do_en), 0, 0);
    check("reset_tw_re", sre(),       0, 0);
    check("reset_tw_im", sim_(),      0, 0);
    @(negedge clock);
    reset = 1'b0;

    // Table-driven single requests.
    for (int v = 0; v < 8; v++) begin
      run_req(vecs[v].k, lat, re, im);
      check($sformatf("latency k=%0d", vecs[v].k), lat, ITER + 1, 0);
      check($sformatf("tw_re k=%0d", vecs[v].k), re, vecs[v].re, vecs[v].tol);
      check($sformatf("tw_im k=%0d", vecs[v].k), im, vecs[v].im, vecs[v].tol);
      if (v == 0) begin
        @(posedge clock);
        #1;
        check("do_en_single_pulse", int'(do_en), 0, 0);
        check("hold_tw_re", sre(),  32767, 0);
        check("hold_tw_im", sim_(), 0, 0);
      end
    end

    // Busy rejection: k=32 offered at busy cycle 5 of a k=8 request.
    @(negedge clock);
    req_en = 1'b1;
    req_k  = 6'd8;
    @(posedge clock);
    #1;
    req_en = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    req_en = 1'b1;
    req_k  = 6'd32;
    @(posedge clock);
    #1;
    req_en = 1'b0;
    pulses = 0;
    keep_re = 0;
    keep_im = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (do_en) begin
        if (pulses == 0) begin
          keep_re = sre();
          keep_im = sim_();
        end
        pulses++;
      end
    end
    check("reject_pulse_count", pulses, 1, 0);
    check("reject_tw_re", keep_re, 23170, 4);
    check("reject_tw_im", keep_im, -23170, 4);

    // Mid-operation reset at busy cycle 9.
    @(negedge clock);
    req_en = 1'b1;
    req_k  = 6'd48;
    @(posedge clock);
    #1;
    req_en = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy",  int'(busy),  0, 0);
    check("abort_do_en", int'(do_en), 0, 0);
    check("abort_tw_re", sre(),  0, 0);
    check("abort_tw_im", sim_(), 0, 0);
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clock);
      #1;
      if (do_en) pulses++;
    end
    check("abort_no_pulse", pulses, 0, 0);
    run_req(16, lat, re, im);
    check("post_abort_latency", lat, ITER + 1, 0);
    check("post_abort_tw_re", re, 0, 0);
    check("post_abort_tw_im", im, -32767, 0);

    // req_en together with reset: reset wins.
    @(negedge clock);
    reset  = 1'b1;
    req_en = 1'b1;
    req_k  = 6'd8;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    req_en = 1'b0;
    check("reset_vs_req_busy", int'(busy), 0, 0);

    // Back-to-back sweep of every index, next request issued in each do_en cycle.
    @(negedge clock);
    req_en = 1'b1;
    req_k  = '0;
    @(posedge clock);
    #1;
    req_en = 1'b0;
    cur = 0;
    pulses = 0;
    ecnt = 0;
    last = 0;
    for (int cyc = 0; cyc < 1200 && pulses < 64; cyc++) begin
      @(posedge clock);
      #1;
      ecnt++;
      req_en = 1'b0;
      if (do_en) begin
        check($sformatf("sweep_re k=%0d", cur), sre(),  ideal_re(cur), 4);
        check($sformatf("sweep_im k=%0d", cur), sim_(), ideal_im(cur), 4);
        if (pulses > 0) check($sformatf("sweep_spacing k=%0d", cur), ecnt - last, ITER + 1, 0);
        last = ecnt;
        pulses++;
        cur++;
        if (cur < 64) begin
          req_en = 1'b1;
          req_k  = cur[LOG_N-1:0];
        end
      end
    end
    req_en = 1'b0;
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (do_en) extra++;
    end
    check("sweep_pulse_count", pulses + extra, 64, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
